bram_req_ctrl: RTL and testbench
================================

Name: bram_req_ctrl

Overview:
Initiator-side controller for the team's single-port block RAM (registered read data, 1-cycle read latency, word-wide writes only). It accepts load/store requests from the core over a valid/ready channel and drives the RAM port (en/we/addr/di). Byte-masked stores become read-modify-write sequences, and every request returns one response over a valid/ready channel. It sits between the core's memory stage and the data/instruction BRAM.

Parameters:
DATA_WIDTH, 32, RAM word width; must be a multiple of 8
ADDR_WIDTH, 10, RAM word-address width
STRB_WIDTH, DATA_WIDTH/8, number of byte strobes (derived; do not override)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&ready
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_WIDTH  word address
req_wdata  in  DATA_WIDTH  store data
req_wstrb  in  STRB_WIDTH  store byte enables; ignored for loads
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumed when valid&ready
rsp_rdata  out  DATA_WIDTH  load data; 0 for store acks
ram_rst  out  1  to RAM rst; = ~rst_n (combinational)
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_WIDTH  RAM address
ram_di  out  DATA_WIDTH  RAM write data
ram_do  in  DATA_WIDTH  RAM registered read data

Behaviour:
- States: IDLE, RD_ISSUE, RD_CAPT, WR_ISSUE, RMW_RD, RMW_MERGE, RMW_WR, RESP.
- Reset (async, rst_n=0): state=IDLE. req_ready=0 while in reset, 1 from the first cycle after release. rsp_valid=0, rsp_rdata=0, ram_en=0, ram_we=0, ram_addr=0, ram_di=0. Latched request registers=0. ram_rst=1.
- req_ready = (state==IDLE). A request is latched (addr, wdata, wstrb, we) on the accepting edge.
- RAM outputs are functions of state and latched registers only, never of live req_* inputs.
- ram_en=1 only in RD_ISSUE, WR_ISSUE, RMW_RD, RMW_WR. ram_we=1 only in WR_ISSUE, RMW_WR. ram_addr = latched addr in all states except IDLE (0).
- Transitions from IDLE on accept:
  - load -> RD_ISSUE
  - store, wstrb all ones -> WR_ISSUE
  - store, wstrb all zeros -> RESP (no RAM access, ack only)
  - store, other wstrb -> RMW_RD
- Load path: RD_ISSUE -> RD_CAPT. RD_CAPT captures ram_do into rsp_rdata -> RESP.
- Full store: WR_ISSUE with ram_di = latched wdata -> RESP, rsp_rdata=0.
- Partial store: RMW_RD -> RMW_MERGE. RMW_MERGE sets merged[8i+7:8i] = wstrb[i] ? wdata byte i : ram_do byte i, stored in a register -> RMW_WR. RMW_WR drives ram_di = merged -> RESP, rsp_rdata=0.
- RESP: rsp_valid=1. rsp_valid and rsp_rdata are held stable until rsp_ready=1, then -> IDLE and rsp_rdata is cleared to 0.
- Latency from accept edge T to first cycle with rsp_valid high: load 3, full store 2, partial store 4, zero-strobe store 1.
- rsp_ready asserted outside RESP has no effect. Back-to-back throughput: one request per (latency+1) cycles with rsp_ready held high.
- Address wrap: none. ADDR_WIDTH covers the whole RAM, and the top address (2^ADDR_WIDTH-1) is legal.
- Reset mid-operation: in-flight request is dropped, no response is issued, and an RMW partial write is never performed if reset arrives before RMW_WR.

Decomposition:
- Shared package: state encoding (3-bit localparams for the 8 states); STRB_WIDTH derivation; ALL_STRB constant.
- One sub-module, bram_byte_merge: purely combinational, inputs old, new, strb; output merged. Parameterised by DATA_WIDTH. Reusable by the store path of the cache.

Test Plan:
1. Reset then load: pre-init RAM[5]=0xDEADBEEF; load addr 5 accepted at T -> ram_en high in T+1 only; rsp_valid at T+3 with rsp_rdata=0xDEADBEEF.
2. Full store then load: store addr 0x3FF, data 0x12345678, wstrb 0xF -> ack at T+2 (rdata 0); load addr 0x3FF returns 0x12345678.
3. Partial store: RAM[7]=0xAABBCCDD; store 0x11223344 wstrb 0x5 -> exactly one read and one write cycle; ack at T+4; load returns 0xAA22CC44.
4. Backpressure: load with rsp_ready low 5 cycles -> rsp_valid and rsp_rdata stable; req_ready stays 0; a new req_valid is not accepted until one cycle after the rsp handshake.
5. Zero-strobe store: wstrb 0x0 -> ram_en never asserted; ack at T+1; RAM unchanged.
6. Reset mid-RMW: assert rst_n=0 in RMW_MERGE -> all outputs 0 immediately, ram_rst=1; after release, RAM[addr] still holds its old value and no response is issued.

Source files
------------

// File: rtl/bram_req_ctrl_pkg.sv
// Shared definitions for the block-RAM request controller: state encoding
// and byte-strobe width helpers.
package bram_req_ctrl_pkg;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_STRB_WIDTH = strb_width(DEF_DATA_WIDTH);
  localparam logic [DEF_STRB_WIDTH-1:0] ALL_STRB = '1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RD_ISSUE  = 3'd1;
  localparam logic [2:0] S_RD_CAPT   = 3'd2;
  localparam logic [2:0] S_WR_ISSUE  = 3'd3;
  localparam logic [2:0] S_RMW_RD    = 3'd4;
  localparam logic [2:0] S_RMW_MERGE = 3'd5;
  localparam logic [2:0] S_RMW_WR    = 3'd6;
  localparam logic [2:0] S_RESP      = 3'd7;

  typedef enum logic [2:0] {
    IDLE      = S_IDLE,
    RD_ISSUE  = S_RD_ISSUE,
    RD_CAPT   = S_RD_CAPT,
    WR_ISSUE  = S_WR_ISSUE,
    RMW_RD    = S_RMW_RD,
    RMW_MERGE = S_RMW_MERGE,
    RMW_WR    = S_RMW_WR,
    RESP      = S_RESP
  } state_t;

endpackage

// File: rtl/bram_req_ctrl_byte_merge.sv
// Combinational byte-lane merge: strobed lanes take the new data, the rest
// keep the old word. Shared with the cache store path.
module bram_byte_merge #(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic [DATA_WIDTH-1:0] old_data,
  input  logic [DATA_WIDTH-1:0] new_data,
  input  logic [STRB_WIDTH-1:0] strb,
  output logic [DATA_WIDTH-1:0] merged
);

  for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_byte
    assign merged[8*gi +: 8] = strb[gi] ? new_data[8*gi +: 8] : old_data[8*gi +: 8];
  end

endmodule

// File: rtl/bram_req_ctrl.sv
// Initiator-side controller for the single-port BRAM: loads, full stores,
// byte-masked stores as read-modify-write, one response per request.
module bram_req_ctrl
  import bram_req_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int STRB_WIDTH = strb_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  ram_rst,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_do
);

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [STRB_WIDTH-1:0]   wstrb_reg;
  logic                    we_reg;
  logic [DATA_WIDTH-1:0]   merged_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;
  logic [DATA_WIDTH-1:0]   merge_out;
  logic                    accept;

  // Ready is gated by rst_n so it reads 0 for the whole reset interval.
  assign req_ready = rst_n && (state_reg == IDLE);
  assign accept    = req_valid && req_ready;
  assign ram_rst   = ~rst_n;
  assign rsp_rdata = rdata_reg;

  bram_byte_merge #(
    .DATA_WIDTH(DATA_WIDTH),
    .STRB_WIDTH(STRB_WIDTH)
  ) u_merge (
    .old_data(ram_do),
    .new_data(wdata_reg),
    .strb    (wstrb_reg),
    .merged  (merge_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      wstrb_reg  <= '0;
      we_reg     <= 1'b0;
      merged_reg <= '0;
      rdata_reg  <= '0;
    end else begin
      state_reg <= state_next;
      rdata_reg <= rdata_next;
      if (accept) begin
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        wstrb_reg <= req_wstrb;
        we_reg    <= req_we;
      end
      // ram_do holds the old word during RMW_MERGE (read issued one cycle earlier).
      if (state_reg == RMW_MERGE) begin
        merged_reg <= merge_out;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    rdata_next = rdata_reg;
    rsp_valid  = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = addr_reg;
    ram_di     = '0;
    case (state_reg)
      IDLE: begin
        ram_addr = '0;
        if (accept) begin
          if (!req_we)          state_next = RD_ISSUE;
          else if (&req_wstrb)  state_next = WR_ISSUE;
          else if (~|req_wstrb) state_next = RESP;
          else                  state_next = RMW_RD;
        end
      end
      RD_ISSUE: begin
        ram_en     = 1'b1;
        state_next = RD_CAPT;
      end
      RD_CAPT: begin
        rdata_next = we_reg ? '0 : ram_do;
        state_next = RESP;
      end
      WR_ISSUE: begin
        ram_en     = 1'b1;
        ram_we     = 1'b1;
        ram_di     = wdata_reg;
        state_next = RESP;
      end
      RMW_RD: begin
        ram_en     = 1'b1;
        state_next = RMW_MERGE;
      end
      RMW_MERGE: begin
        state_next = RMW_WR;
      end
      RMW_WR: begin
        ram_en     = 1'b1;
        ram_we     = 1'b1;
        ram_di     = merged_reg;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rdata_next = '0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bram_req_ctrl.sv
// Bench for bram_req_ctrl: behavioural RAM, a latency-timeline model checked
// every cycle, and directed requests with literal expectations.
module tb_bram_req_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        ram_rst;
  logic        ram_en;
  logic        ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_di;
  logic [31:0] ram_do;

  int n_cmp = 0;
  int n_bad = 0;

  bram_req_ctrl #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(10)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .ram_rst  (ram_rst),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_di   (ram_di),
    .ram_do   (ram_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM with registered read and a backdoor preload port.
  logic [31:0] mem [1024];
  logic        bd_en;
  logic [9:0]  bd_addr;
  logic [31:0] bd_data;

  always @(posedge clk) begin
    if (bd_en) begin
      mem[bd_addr] <= bd_data;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_di;
      ram_do <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge_bytes(input logic [31:0] o, input logic [31:0] n,
                                              input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  // Timeline model: k counts cycles since the accept edge; kind 0=load,
  // 1=full store, 2=partial store, 3=zero-strobe store.
  logic        m_busy;
  int          m_k;
  int          m_lat;
  logic [1:0]  m_kind;
  logic [9:0]  m_addr;
  logic [31:0] m_rdata;
  logic [31:0] m_di;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_k    <= 0;
    end else if (!m_busy) begin
      if (req_valid) begin
        m_busy <= 1'b1;
        m_k    <= 1;
        m_addr <= req_addr;
        m_rdata <= 32'h0;
        m_di    <= 32'h0;
        if (!req_we) begin
          m_kind <= 2'd0; m_lat <= 3; m_rdata <= mem[req_addr];
        end else if (req_wstrb == 4'hF) begin
          m_kind <= 2'd1; m_lat <= 2; m_di <= req_wdata;
        end else if (req_wstrb == 4'h0) begin
          m_kind <= 2'd3; m_lat <= 1;
        end else begin
          m_kind <= 2'd2; m_lat <= 4; m_di <= merge_bytes(mem[req_addr], req_wdata, req_wstrb);
        end
      end
    end else if (m_k >= m_lat && rsp_ready) begin
      m_busy <= 1'b0;
    end else begin
      m_k <= m_k + 1;
    end
  end

  function automatic logic exp_we();
    return m_busy && ((m_k == 1 && m_kind == 2'd1) || (m_k == 3 && m_kind == 2'd2));
  endfunction

  function automatic logic exp_en();
    return m_busy && ((m_k == 1 && m_kind != 2'd3) || (m_k == 3 && m_kind == 2'd2));
  endfunction

  function automatic logic exp_rv();
    return m_busy && (m_k >= m_lat);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("req_ready", 32'(req_ready), 32'(!m_busy));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rv()));
      check("rsp_rdata", rsp_rdata, (exp_rv() && m_kind == 2'd0) ? m_rdata : 32'h0);
      check("ram_en",    32'(ram_en), 32'(exp_en()));
      check("ram_we",    32'(ram_we), 32'(exp_we()));
      check("ram_addr",  32'(ram_addr), m_busy ? 32'(m_addr) : 32'h0);
      check("ram_di",    ram_di, exp_we() ? m_di : 32'h0);
      check("ram_rst",   32'(ram_rst), 32'h0);
    end
  end

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_addr = a; bd_data = d; bd_en = 1'b1;
    @(negedge clk);
    bd_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    check({tag, "_ram_en"},    32'(ram_en), 32'h0);
    check({tag, "_ram_we"},    32'(ram_we), 32'h0);
    check({tag, "_ram_addr"},  32'(ram_addr), 32'h0);
    check({tag, "_ram_di"},    ram_di, 32'h0);
    check({tag, "_ram_rst"},   32'(ram_rst), 32'h1);
  endtask

  // Called just after a rising edge; returns just after the response handshake edge.
  // With pend set, a load of address 5 is raised while the response is held off.
  task automatic do_req(input logic we, input logic [9:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input int hold, input logic pend,
                        output int lat, output logic [31:0] rd,
                        output int en_n, output int we_n);
    int guard;
    req_we = we; req_addr = a; req_wdata = wd; req_wstrb = ws; req_valid = 1'b1;
    guard = 0;
    lat = 0; rd = 32'h0; en_n = 0; we_n = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'(req_ready), 32'h1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      if (ram_en) en_n++;
      if (ram_we) we_n++;
    end while (!rsp_valid && lat < 20);
    if (!rsp_valid) begin
      check("rsp_timeout", 32'(rsp_valid), 32'h1);
      return;
    end
    rd = rsp_rdata;
    if (pend) begin
      req_we = 1'b0; req_addr = 10'd5; req_wdata = 32'h0; req_wstrb = 4'h0; req_valid = 1'b1;
    end
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, en_n, we_n;
    logic [31:0] rd;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b0;
    bd_en = 1'b0; bd_addr = '0; bd_data = '0;

    preload(10'd5,   32'hDEADBEEF);
    preload(10'd7,   32'hAABBCCDD);
    preload(10'd9,   32'h55667788);
    preload(10'h020, 32'hCAFEF00D);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 32'(req_ready), 32'h1);

    // 1: load
    do_req(1'b0, 10'd5, 32'h0, 4'h0, 0, 1'b0, lat, rd, en_n, we_n);
    check("t1_lat", lat, 3);
    check("t1_rdata", rd, 32'hDEADBEEF);
    check("t1_en_cycles", en_n, 1);
    check("t1_we_cycles", we_n, 0);

    // 2: full store to the top address, then read back
    do_req(1'b1, 10'h3FF, 32'h12345678, 4'hF, 0, 1'b0, lat, rd, en_n, we_n);
    check("t2_lat", lat, 2);
    check("t2_rdata", rd, 32'h0);
    check("t2_we_cycles", we_n, 1);
    do_req(1'b0, 10'h3FF, 32'h0, 4'h0, 0, 1'b0, lat, rd, en_n, we_n);
    check("t2_load", rd, 32'h12345678);

    // 3: partial store (read-modify-write)
    do_req(1'b1, 10'd7, 32'h11223344, 4'h5, 0, 1'b0, lat, rd, en_n, we_n);
    check("t3_lat", lat, 4);
    check("t3_rdata", rd, 32'h0);
    check("t3_en_cycles", en_n, 2);
    check("t3_we_cycles", we_n, 1);
    do_req(1'b0, 10'd7, 32'h0, 4'h0, 0, 1'b0, lat, rd, en_n, we_n);
    check("t3_load", rd, 32'hAA22CC44);

    // 4: backpressure with a pending request queued behind it
    do_req(1'b0, 10'd7, 32'h0, 4'h0, 5, 1'b1, lat, rd, en_n, we_n);
    check("t4_rdata", rd, 32'hAA22CC44);
    check("t4_ready_after_hs", 32'(req_ready), 32'h1);
    do_req(1'b0, 10'd5, 32'h0, 4'h0, 0, 1'b0, lat, rd, en_n, we_n);
    check("t4_pending_lat", lat, 3);
    check("t4_pending_rdata", rd, 32'hDEADBEEF);

    // 5: zero-strobe store
    do_req(1'b1, 10'h020, 32'hFFFFFFFF, 4'h0, 0, 1'b0, lat, rd, en_n, we_n);
    check("t5_lat", lat, 1);
    check("t5_en_cycles", en_n, 0);
    check("t5_rdata", rd, 32'h0);
    check("t5_ram_unchanged", mem[10'h020], 32'hCAFEF00D);

    // Extra: single top-byte store
    do_req(1'b1, 10'd5, 32'h77000000, 4'h8, 0, 1'b0, lat, rd, en_n, we_n);
    do_req(1'b0, 10'd5, 32'h0, 4'h0, 0, 1'b0, lat, rd, en_n, we_n);
    check("x_top_byte_load", rd, 32'h77ADBEEF);

    // 6: reset during RMW_MERGE
    req_we = 1'b1; req_addr = 10'd9; req_wdata = 32'hAAAAAAAA; req_wstrb = 4'h3; req_valid = 1'b1;
    check("t6_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("t6_no_rsp", 32'(rsp_valid), 32'h0);
    check("t6_ram_unchanged", mem[10'd9], 32'h55667788);

    @(posedge clk); #1;
    do_req(1'b0, 10'd9, 32'h0, 4'h0, 0, 1'b0, lat, rd, en_n, we_n);
    check("t6_load_after", rd, 32'h55667788);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
